// File: rtl/fft_stage_engine.sv
// One radix-2 decimation-in-time stage over an N-point frame buffer.
// Loads N beats, then streams two result beats per butterfly.
module fft_stage_engine #(
  parameter int BIT_WIDTH = 24,
  parameter int N         = 16,
  parameter int SIZE      = 4,
  parameter int STAGE     = 1,
  parameter int TW_WIDTH  = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  input  logic [BIT_WIDTH-1:0] Re_i,
  input  logic [BIT_WIDTH-1:0] Im_i,
  input  logic [SIZE-1:0]      wr_ptr_i,
  output logic                 in_ready_o,
  input  logic                 inverse_i,
  input  logic                 scale_i,
  output logic [SIZE-2:0]      tw_addr_o,
  input  logic [TW_WIDTH-1:0]  tw_cos_i,
  input  logic [TW_WIDTH-1:0]  tw_sin_i,
  output logic [BIT_WIDTH-1:0] Re_o,
  output logic [BIT_WIDTH-1:0] Im_o,
  output logic [SIZE-1:0]      wr_ptr_o,
  output logic                 en_o,
  output logic                 done_o
);
  localparam int CW   = SIZE + 1;
  localparam int XW   = BIT_WIDTH + 2;
  localparam int PW   = BIT_WIDTH + TW_WIDTH + 2;
  localparam int SPAN = 1 << (STAGE - 1);
  localparam logic signed [XW-1:0] SMAX =
    {3'b000, {(BIT_WIDTH-1){1'b1}}};
  localparam logic signed [XW-1:0] SMIN = -SMAX;

  typedef enum logic {LOAD, PROC} state_t;

  state_t              state_q, state_d;
  logic [SIZE-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]       cyc_q, cyc_d;
  logic                inv_q, inv_d;
  logic                scl_q, scl_d;
  logic                s1_v_q, s1_v_d;
  logic                s2_v_q, s2_v_d;
  logic                bq_v_q, bq_v_d;
  logic [BIT_WIDTH-1:0] re_q, re_d, im_q, im_d;
  logic [SIZE-1:0]     ptr_q, ptr_d;
  logic                en_q, en_d, done_q, done_d;

  logic [BIT_WIDTH-1:0] mem_re_q [N];
  logic [BIT_WIDTH-1:0] mem_im_q [N];
  logic                 wr_en, iss;
  logic [SIZE-1:0]      k, j, top, bot;

  logic signed [BIT_WIDTH-1:0] a_re_q, a_re_d, a_im_q, a_im_d;
  logic signed [BIT_WIDTH-1:0] b_re_q, b_re_d, b_im_q, b_im_d;
  logic [SIZE-1:0]             s1_top_q, s1_top_d;
  logic [SIZE-1:0]             s1_bot_q, s1_bot_d;
  logic signed [BIT_WIDTH-1:0] s2_a_re_q, s2_a_re_d;
  logic signed [BIT_WIDTH-1:0] s2_a_im_q, s2_a_im_d;
  logic signed [XW-1:0]        t_re_q, t_re_d, t_im_q, t_im_d;
  logic [SIZE-1:0]             s2_top_q, s2_top_d;
  logic [SIZE-1:0]             s2_bot_q, s2_bot_d;
  logic [BIT_WIDTH-1:0]        bq_re_q, bq_re_d, bq_im_q, bq_im_d;
  logic [SIZE-1:0]             bq_ptr_q, bq_ptr_d;

  logic signed [PW-1:0] c_x, s_x, br_x, bi_x, p_re, p_im;
  logic signed [XW-1:0] ar_x, ai_x, sa_re, sa_im, sb_re, sb_im;

  function automatic logic [BIT_WIDTH-1:0] sat(
    input logic signed [XW-1:0] v
  );
    logic signed [XW-1:0] r;
    r = v;
    if (v > SMAX) r = SMAX;
    else if (v < SMIN) r = SMIN;
    return r[BIT_WIDTH-1:0];
  endfunction

  assign in_ready_o = (state_q == LOAD);
  assign Re_o       = re_q;
  assign Im_o       = im_q;
  assign wr_ptr_o   = ptr_q;
  assign en_o       = en_q;
  assign done_o     = done_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    inv_d   = inv_q;
    scl_d   = scl_q;
    wr_en   = 1'b0;
    unique case (state_q)
      LOAD: begin
        cyc_d = '0;
        if (valid_i) begin
          wr_en = !rst;
          if (cnt_q == SIZE'(N - 1)) begin
            cnt_d   = '0;
            state_d = PROC;
            inv_d   = inverse_i;
            scl_d   = scale_i;
          end else begin
            cnt_d = cnt_q + SIZE'(1);
          end
        end
      end
      PROC: begin
        if (cyc_q == CW'(N + 2)) begin
          state_d = LOAD;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
    endcase
  end

  // Butterfly k is issued on even PROC cycles 2k.
  always_comb begin
    iss = (state_q == PROC) && (cyc_q < CW'(N)) && !cyc_q[0];
    k   = SIZE'(cyc_q >> 1);
    j   = k & SIZE'(SPAN - 1);
    top = ((k >> (STAGE - 1)) << STAGE) | j;
    bot = top + SIZE'(SPAN);
    tw_addr_o = iss ? (SIZE-1)'(j << (SIZE - STAGE)) : '0;
  end

  always_comb begin
    a_re_d   = mem_re_q[top];
    a_im_d   = mem_im_q[top];
    b_re_d   = mem_re_q[bot];
    b_im_d   = mem_im_q[bot];
    s1_top_d = top;
    s1_bot_d = bot;
    c_x  = {{(PW-TW_WIDTH){tw_cos_i[TW_WIDTH-1]}}, tw_cos_i};
    s_x  = {{(PW-TW_WIDTH){tw_sin_i[TW_WIDTH-1]}}, tw_sin_i};
    if (inv_q) s_x = -s_x;
    br_x = {{(PW-BIT_WIDTH){b_re_q[BIT_WIDTH-1]}}, b_re_q};
    bi_x = {{(PW-BIT_WIDTH){b_im_q[BIT_WIDTH-1]}}, b_im_q};
    p_re = br_x * c_x - bi_x * s_x;
    p_im = br_x * s_x + bi_x * c_x;
    t_re_d    = XW'(p_re >>> (TW_WIDTH - 2));
    t_im_d    = XW'(p_im >>> (TW_WIDTH - 2));
    s2_a_re_d = a_re_q;
    s2_a_im_d = a_im_q;
    s2_top_d  = s1_top_q;
    s2_bot_d  = s1_bot_q;
    ar_x  = {{2{s2_a_re_q[BIT_WIDTH-1]}}, s2_a_re_q};
    ai_x  = {{2{s2_a_im_q[BIT_WIDTH-1]}}, s2_a_im_q};
    sa_re = ar_x + t_re_q;
    sa_im = ai_x + t_im_q;
    sb_re = ar_x - t_re_q;
    sb_im = ai_x - t_im_q;
    if (scl_q) begin
      sa_re = sa_re >>> 1;
      sa_im = sa_im >>> 1;
      sb_re = sb_re >>> 1;
      sb_im = sb_im >>> 1;
    end
    bq_re_d  = sat(sb_re);
    bq_im_d  = sat(sb_im);
    bq_ptr_d = s2_bot_q;
  end

  // A leaves the cycle after its sum, B is parked one more cycle.
  always_comb begin
    s1_v_d = iss;
    s2_v_d = s1_v_q;
    bq_v_d = s2_v_q;
    re_d   = re_q;
    im_d   = im_q;
    ptr_d  = ptr_q;
    en_d   = 1'b0;
    done_d = 1'b0;
    if (s2_v_q) begin
      re_d  = sat(sa_re);
      im_d  = sat(sa_im);
      ptr_d = s2_top_q;
      en_d  = 1'b1;
    end else if (bq_v_q) begin
      re_d   = bq_re_q;
      im_d   = bq_im_q;
      ptr_d  = bq_ptr_q;
      en_d   = 1'b1;
      done_d = (cyc_q == CW'(N + 1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      cyc_q   <= '0;
      inv_q   <= 1'b0;
      scl_q   <= 1'b0;
      s1_v_q  <= 1'b0;
      s2_v_q  <= 1'b0;
      bq_v_q  <= 1'b0;
      re_q    <= '0;
      im_q    <= '0;
      ptr_q   <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      inv_q   <= inv_d;
      scl_q   <= scl_d;
      s1_v_q  <= s1_v_d;
      s2_v_q  <= s2_v_d;
      bq_v_q  <= bq_v_d;
      re_q    <= re_d;
      im_q    <= im_d;
      ptr_q   <= ptr_d;
      en_q    <= en_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_re_q[wr_ptr_i] <= Re_i;
      mem_im_q[wr_ptr_i] <= Im_i;
    end
    a_re_q    <= a_re_d;
    a_im_q    <= a_im_d;
    b_re_q    <= b_re_d;
    b_im_q    <= b_im_d;
    s1_top_q  <= s1_top_d;
    s1_bot_q  <= s1_bot_d;
    s2_a_re_q <= s2_a_re_d;
    s2_a_im_q <= s2_a_im_d;
    t_re_q    <= t_re_d;
    t_im_q    <= t_im_d;
    s2_top_q  <= s2_top_d;
    s2_bot_q  <= s2_bot_d;
    bq_re_q   <= bq_re_d;
    bq_im_q   <= bq_im_d;
    bq_ptr_q  <= bq_ptr_d;
  end
endmodule

// File: tb/tb_fft_stage_engine.sv
// Scoreboard bench for fft_stage_engine: stage-1 and stage-4 instances,
// directed frames with hand-computed beats, timing checked per beat.
module tb_fft_stage_engine;
  localparam int BW = 24;
  localparam int N  = 16;
  localparam int SZ = 4;
  localparam int TW = 14;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic v1 = 1'b0, v4 = 1'b0;
  logic [BW-1:0] re_i = '0, im_i = '0;
  logic [SZ-1:0] ptr_i = '0;
  logic inv_i = 1'b0, scl_i = 1'b0;
  logic rdy1, rdy4;
  logic [SZ-2:0] tw1, tw4;
  logic [TW-1:0] c1, s1, c4, s4;
  logic [BW-1:0] re1, im1, re4, im4;
  logic [SZ-1:0] p1, p4;
  logic en1, en4, dn1, dn4;

  int cyc_n = 0;
  int n_assert = 0;
  int n_fail = 0;
  int xr[N], xi[N], xa[N];
  int p0;

  typedef struct {
    int ptr; int re; int im; bit done; int t;
  } beat_t;
  beat_t q1[$], q4[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  always @(posedge clk) begin
    c1 <= TW'(4096);
    s1 <= '0;
    c4 <= (tw4 == 3'd4) ? '0 : TW'(4096);
    s4 <= (tw4 == 3'd4) ? TW'(-4096) : '0;
  end

  fft_stage_engine #(.BIT_WIDTH(BW), .N(N), .SIZE(SZ),
                     .STAGE(1), .TW_WIDTH(TW)) u1 (
    .clk(clk), .rst(rst), .valid_i(v1), .Re_i(re_i), .Im_i(im_i),
    .wr_ptr_i(ptr_i), .in_ready_o(rdy1), .inverse_i(inv_i),
    .scale_i(scl_i), .tw_addr_o(tw1), .tw_cos_i(c1), .tw_sin_i(s1),
    .Re_o(re1), .Im_o(im1), .wr_ptr_o(p1), .en_o(en1), .done_o(dn1)
  );

  fft_stage_engine #(.BIT_WIDTH(BW), .N(N), .SIZE(SZ),
                     .STAGE(4), .TW_WIDTH(TW)) u4 (
    .clk(clk), .rst(rst), .valid_i(v4), .Re_i(re_i), .Im_i(im_i),
    .wr_ptr_i(ptr_i), .in_ready_o(rdy4), .inverse_i(inv_i),
    .scale_i(scl_i), .tw_addr_o(tw4), .tw_cos_i(c4), .tw_sin_i(s4),
    .Re_o(re4), .Im_o(im4), .wr_ptr_o(p4), .en_o(en4), .done_o(dn4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc_n < c) tick();
  endtask

  task automatic check(input string name, input int got, input int want);
    n_assert++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic clear_x();
    for (int i = 0; i < N; i++) begin
      xr[i] = 0;
      xi[i] = 0;
      xa[i] = i;
    end
  endtask

  task automatic send(input bit sel, output int pc0);
    for (int i = 0; i < N; i++) begin
      re_i  = BW'(xr[i]);
      im_i  = BW'(xi[i]);
      ptr_i = SZ'(xa[i]);
      v1    = !sel;
      v4    = sel;
      tick();
    end
    v1  = 1'b0;
    v4  = 1'b0;
    pc0 = cyc_n;
  endtask

  task automatic push(input bit sel, input int ptr, input int re,
                      input int im, input bit dn, input int t);
    beat_t e;
    e.ptr = ptr; e.re = re; e.im = im; e.done = dn; e.t = t;
    if (sel) q4.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic push_bfly(input bit sel, input int pc0, input int k,
                           input int at, input int are, input int aim,
                           input int bb, input int bre, input int bim);
    push(sel, at, are, aim, 1'b0, pc0 + 2*k + 3);
    push(sel, bb, bre, bim, k == N/2 - 1, pc0 + 2*k + 4);
  endtask

  task automatic mon_one(input bit sel, input logic en, input logic dn,
                         input logic [SZ-1:0] p,
                         input logic [BW-1:0] re,
                         input logic [BW-1:0] im);
    beat_t e;
    if (en) begin
      n_assert++;
      if ((sel ? q4.size() : q1.size()) == 0) begin
        n_fail++;
        $display("FAIL beat_u%0d: got unexpected ptr=%0d re=%0d at t=%0d, want no beat",
                 sel ? 4 : 1, p, $signed(re), cyc_n);
      end else begin
        e = sel ? q4.pop_front() : q1.pop_front();
        if (p != e.ptr || $signed(re) != e.re || $signed(im) != e.im ||
            dn != e.done || cyc_n != e.t) begin
          n_fail++;
          $display("FAIL beat_u%0d: got ptr=%0d re=%0d im=%0d done=%0b t=%0d, want ptr=%0d re=%0d im=%0d done=%0b t=%0d",
                   sel ? 4 : 1, p, $signed(re), $signed(im), dn, cyc_n,
                   e.ptr, e.re, e.im, e.done, e.t);
        end
      end
    end else if (dn) begin
      n_assert++;
      n_fail++;
      $display("FAIL done_u%0d: got done without en at t=%0d, want 0",
               sel ? 4 : 1, cyc_n);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      mon_one(1'b0, en1, dn1, p1, re1, im1);
      mon_one(1'b1, en4, dn4, p4, re4, im4);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

  initial begin
    fork
      monitor();
    join_none

    rst = 1'b1;
    repeat (3) tick();
    check("rst_rdy1", int'(rdy1), 1);
    check("rst_en1", int'(en1), 0);
    check("rst_done1", int'(dn1), 0);
    check("rst_re1", int'(re1), 0);
    check("rst_im1", int'(im1), 0);
    check("rst_ptr1", int'(p1), 0);
    check("rst_tw1", int'(tw1), 0);
    check("rst_rdy4", int'(rdy4), 1);
    rst = 1'b0;
    tick();

    clear_x();
    xr[0] = 1000;
    send(1'b0, p0);
    push_bfly(1'b0, p0, 0, 0, 1000, 0, 1, 1000, 0);
    for (int k = 1; k < N/2; k++)
      push_bfly(1'b0, p0, k, 2*k, 0, 0, 2*k+1, 0, 0);
    wait_until(p0 + 10);
    check("proc_rdy1", int'(rdy1), 0);
    wait_until(p0 + 19);
    check("after_rdy1", int'(rdy1), 1);

    clear_x();
    xr[12] = 1000;
    send(1'b1, p0);
    for (int k = 0; k < N/2; k++)
      push_bfly(1'b1, p0, k, k, 0, (k == 4) ? -1000 : 0,
                k + 8, 0, (k == 4) ? 1000 : 0);
    wait_until(p0 + 8);
    check("tw4_addr", int'(tw4), 4);
    wait_until(p0 + 19);

    inv_i = 1'b1;
    send(1'b1, p0);
    inv_i = 1'b0;
    for (int k = 0; k < N/2; k++)
      push_bfly(1'b1, p0, k, k, 0, (k == 4) ? 1000 : 0,
                k + 8, 0, (k == 4) ? -1000 : 0);
    wait_until(p0 + 19);

    clear_x();
    xr[0] = 1001;
    scl_i = 1'b1;
    send(1'b0, p0);
    scl_i = 1'b0;
    push_bfly(1'b0, p0, 0, 0, 500, 0, 1, 500, 0);
    for (int k = 1; k < N/2; k++)
      push_bfly(1'b0, p0, k, 2*k, 0, 0, 2*k+1, 0, 0);
    wait_until(p0 + 19);

    xr[0] = -1001;
    scl_i = 1'b1;
    send(1'b0, p0);
    scl_i = 1'b0;
    push_bfly(1'b0, p0, 0, 0, -501, 0, 1, -501, 0);
    for (int k = 1; k < N/2; k++)
      push_bfly(1'b0, p0, k, 2*k, 0, 0, 2*k+1, 0, 0);
    wait_until(p0 + 19);

    clear_x();
    xr[0] = 8388607;
    xr[1] = 8388607;
    xr[2] = -8388607;
    xr[3] = -8388607;
    xi[4] = 8388607;
    xi[5] = -8388607;
    send(1'b0, p0);
    push_bfly(1'b0, p0, 0, 0, 8388607, 0, 1, 0, 0);
    push_bfly(1'b0, p0, 1, 2, -8388607, 0, 3, 0, 0);
    push_bfly(1'b0, p0, 2, 4, 0, 0, 5, 0, 8388607);
    for (int k = 3; k < N/2; k++)
      push_bfly(1'b0, p0, k, 2*k, 0, 0, 2*k+1, 0, 0);
    wait_until(p0 + 19);

    clear_x();
    xr[0] = 300;
    xr[1] = 100;
    send(1'b0, p0);
    push_bfly(1'b0, p0, 0, 0, 400, 0, 1, 200, 0);
    for (int k = 1; k < N/2; k++)
      push_bfly(1'b0, p0, k, 2*k, 0, 0, 2*k+1, 0, 0);
    wait_until(p0 + 2);
    v1    = 1'b1;
    ptr_i = '0;
    re_i  = BW'(7777);
    im_i  = BW'(55);
    check("hs_rdy1", int'(rdy1), 0);
    wait_until(p0 + 6);
    v1 = 1'b0;
    wait_until(p0 + 19);

    clear_x();
    for (int i = 0; i < N; i++) xa[i] = 2;
    send(1'b0, p0);
    push_bfly(1'b0, p0, 0, 0, 400, 0, 1, 200, 0);
    for (int k = 1; k < N/2; k++)
      push_bfly(1'b0, p0, k, 2*k, 0, 0, 2*k+1, 0, 0);
    wait_until(p0 + 19);

    clear_x();
    xr[0] = 10;
    xr[1] = 20;
    xr[2] = 30;
    xr[3] = 40;
    send(1'b0, p0);
    push_bfly(1'b0, p0, 0, 0, 30, 0, 1, -10, 0);
    push(1'b0, 2, 70, 0, 1'b0, p0 + 5);
    wait_until(p0 + 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_rdy1", int'(rdy1), 1);
    check("abort_en1", int'(en1), 0);
    wait_until(p0 + 26);

    clear_x();
    for (int i = 0; i < N; i++) begin
      xr[i] = 100 * i;
      xi[i] = -i;
    end
    send(1'b0, p0);
    for (int k = 0; k < N/2; k++)
      push_bfly(1'b0, p0, k, 2*k, 100 * (4*k + 1), -(4*k + 1),
                2*k + 1, -100, 1);
    wait_until(p0 + 21);

    check("q1_left", q1.size(), 0);
    check("q4_left", q4.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/fft_stage_engine.md
FFT_STAGE_ENGINE -- requirements
Module: fft_stage_engine

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 24: sample component width, two's complement.
REQ-002 SHALL have parameter N, default 16: points per frame, power of two, at least 4.
REQ-003 SHALL have parameter SIZE, default 4: log2(N).
REQ-004 SHALL have parameter STAGE, default 1: decimation-in-time stage index, 1..SIZE.
REQ-005 SHALL have parameter TW_WIDTH, default 14: twiddle width, Q1.(TW_WIDTH-2) format, so 1.0 = 4096.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have ports valid_i, input, 1 bit; Re_i and Im_i, input, BIT_WIDTH each; wr_ptr_i, input, SIZE: input sample beat and its buffer address.
REQ-009 SHALL have port in_ready_o, output, 1 bit: high only while in LOAD.
REQ-010 SHALL have ports inverse_i and scale_i, input, 1 bit each: conjugate-twiddle mode and divide-by-2 mode.
REQ-011 SHALL have port tw_addr_o, output, SIZE-1: twiddle ROM address.
REQ-012 SHALL have ports tw_cos_i and tw_sin_i, input, TW_WIDTH each: ROM data, one-cycle read latency.
REQ-013 SHALL have ports Re_o and Im_o, output, BIT_WIDTH each; wr_ptr_o, output, SIZE; en_o, output, 1 bit: result beat.
REQ-014 SHALL have port done_o, output, 1 bit: frame-complete pulse.

Function
REQ-015 SHALL implement FSM LOAD -> PROC -> LOAD; PROC includes pipeline drain.
REQ-016 In LOAD, each valid_i beat SHALL write Re_i/Im_i to buffer[wr_ptr_i] and increment a beat counter.
- Duplicate addresses overwrite and still count.
REQ-017 On the Nth accepted beat the FSM SHALL enter PROC next cycle and clear the counter.
- inverse_i and scale_i are latched on that same Nth beat.
REQ-018 In PROC, valid_i SHALL be ignored and no buffer writes SHALL occur.
REQ-019 Butterfly k, for k = 0..N/2-1, SHALL compute its operand addresses as follows:
- span = 2^(STAGE-1); j = k mod span
- top = (k div span)*2*span + j; bot = top + span
REQ-020 Butterfly k SHALL issue reads of top and bot at PROC cycle 2k, where cycle 0 is the first PROC cycle.
- The buffer has two synchronous read ports.
- tw_addr_o = j*(N/(2*span)) is driven in the same cycle.
REQ-021 Twiddle SHALL be W = c + j*s, with c = tw_cos_i and s = tw_sin_i; s SHALL be negated when inverse is latched.
REQ-022 SHALL compute t = b*W at full product width, then arithmetic-shift right by TW_WIDTH-2.
REQ-023 SHALL compute A = a+t and B = a-t at BIT_WIDTH+2 width.
- If scale is latched: arithmetic shift right by 1 (floor).
- Then saturate to +/-(2^(BIT_WIDTH-1)-1).
REQ-024 SHALL present A at cycle 2k+3 with wr_ptr_o = top, and B at cycle 2k+4 with wr_ptr_o = bot; en_o is high for exactly those cycles.
REQ-025 done_o SHALL pulse together with the last B beat, at cycle N+2.
- FSM is in LOAD the following cycle, in_ready_o high.
REQ-026 Buffer contents SHALL NOT be cleared between frames.

Reset
REQ-027 While rst is high, at the next edge:
- FSM goes to LOAD and the beat counter is cleared.
- en_o, done_o, tw_addr_o, wr_ptr_o, Re_o and Im_o go to 0; in_ready_o goes to 1.
- The pipeline is flushed.
REQ-028 Reset during PROC SHALL abort the frame with no further en_o beats; buffer RAM contents are don't-care.

Verification
REQ-029 Impulse test, STAGE=1, N=16: load x[0]=1000, all others 0, ROM c=4096, s=0 -> beats (addr 0, 1000), (addr 1, 1000), all remaining 14 beats 0, done_o at cycle 18.
REQ-030 Twiddle test, STAGE=4: a=x[4]=0, b=x[12]=1000+0j, tw_addr_o=4, ROM c=0, s=-4096.
- Forward -> A=(0,-1000), B=(0,1000).
- inverse_i=1 -> A=(0,1000), B=(0,-1000).
REQ-031 Scale test, STAGE=1: x[0]=1001, x[1]=0, scale_i=1 -> A=500, B=500; with x[0]=-1001 -> A=-501, B=-501.
REQ-032 Saturation test, STAGE=1, scale_i=0: x[0]=x[1]=8388607 -> A=8388607 (saturated), B=0.
REQ-033 Reset test: assert rst at PROC cycle 5 -> no further en_o or done_o; in_ready_o=1 next cycle; the next 16-beat frame processes correctly.
REQ-034 Handshake test: drive valid_i during PROC -> in_ready_o=0 and the buffer is unchanged; a 17th beat after reload starts a new count.
